// File: rtl/logic_sweep_checker_if.sv
// logic_sweep_checker_if: start/stimulus/result bundle between sweep checker and its environment
interface logic_sweep_checker_if;
  logic        start;
  logic        a, b, c, d;
  logic        out_in, out_n_in;
  logic        busy, done, pass;
  logic [15:0] truth_table;
  logic        comp_err;
  logic [3:0]  err_index;
  modport master (
    output start, out_in, out_n_in,
    input  a, b, c, d, busy, done, pass, truth_table, comp_err, err_index
  );
  modport slave (
    input  start, out_in, out_n_in,
    output a, b, c, d, busy, done, pass, truth_table, comp_err, err_index
  );
endinterface

// File: rtl/logic_sweep_checker.sv
// logic_sweep_checker: exhaustive 16-code sweep of a 4-input block with truth-table and complement check
module logic_sweep_checker #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = 16'h8000
) (
  input logic clk,
  input logic rst,
  logic_sweep_checker_if.slave s
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;
  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [15:0]   tt_q, tt_d;
  logic          comp_err_q, comp_err_d;
  logic [3:0]    err_index_q, err_index_d;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    tt_d        = tt_q;
    comp_err_d  = comp_err_q;
    err_index_d = err_index_q;
    case (state_q)
      IDLE: if (s.start) begin
        idx_d       = 4'd0;
        cnt_d       = '0;
        busy_d      = 1'b1;
        done_d      = 1'b0;
        pass_d      = 1'b0;
        tt_d        = 16'h0000;
        comp_err_d  = 1'b0;
        err_index_d = 4'd0;
        state_d     = SETTLE;
      end
      SETTLE: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        tt_d[idx_q] = s.out_in;
        if (s.out_n_in == s.out_in && !comp_err_q) begin
          comp_err_d  = 1'b1;
          err_index_d = idx_q;
        end
        cnt_d   = '0;
        idx_d   = (idx_q == 4'd15) ? idx_q : idx_q + 4'd1;
        state_d = (idx_q == 4'd15) ? FINISH : SETTLE;
      end
      FINISH: begin
        pass_d  = (tt_q == EXPECTED_TT) && !comp_err_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tt_q        <= 16'h0000;
      comp_err_q  <= 1'b0;
      err_index_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tt_q        <= tt_d;
      comp_err_q  <= comp_err_d;
      err_index_q <= err_index_d;
    end
  end
  assign {s.d, s.c, s.b, s.a} = (state_q == SETTLE || state_q == SAMPLE) ? idx_q : 4'd0;
  assign s.busy        = busy_q;
  assign s.done        = done_q;
  assign s.pass        = pass_q;
  assign s.truth_table = tt_q;
  assign s.comp_err    = comp_err_q;
  assign s.err_index   = err_index_q;
endmodule

// File: tb/tb_logic_sweep_checker.sv
// tb_logic_sweep_checker: scoreboard bench driving AND/XOR/faulty models through the sweep checker
module tb_logic_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic_sweep_checker_if bus();
  logic_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED_TT(16'h8000)) dut (
    .clk(clk),
    .rst(rst),
    .s(bus.slave)
  );
  logic       xor_mode = 1'b0;
  logic       fault = 1'b0;
  logic [3:0] abcd;
  assign abcd = {bus.d, bus.c, bus.b, bus.a};
  assign bus.out_in = xor_mode ? ^abcd : &abcd;
  assign bus.out_n_in = (fault && abcd == 4'd5) ? bus.out_in : ~bus.out_in;
  typedef struct {
    logic [15:0] tt;
    logic        pass;
    logic        cerr;
    logic [3:0]  eidx;
  } exp_t;
  exp_t sb[$];
  int n_pass = 0;
  int n_tot = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic exp_t predict();
    exp_t e;
    logic [3:0] v;
    logic o, on;
    e.tt = 16'h0;
    e.cerr = 1'b0;
    e.eidx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      o = xor_mode ? ^v : &v;
      on = (fault && i == 5) ? o : ~o;
      e.tt[i] = o;
      if (on == o && !e.cerr) begin
        e.cerr = 1'b1;
        e.eidx = v;
      end
    end
    e.pass = (e.tt == 16'h8000) && !e.cerr;
    return e;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_tt"}, bus.truth_table, 0);
    chk({tag, "_cerr"}, bus.comp_err, 0);
    chk({tag, "_eidx"}, bus.err_index, 0);
    chk({tag, "_abcd"}, abcd, 0);
  endtask
  task automatic sweep(input bit order);
    int done_at;
    exp_t e;
    done_at = -1;
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back(predict());
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("busy_on", bus.busy, 1);
    chk("done_clr", bus.done, 0);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_at = k;
      if (order) begin
        if (k < 49) chk($sformatf("abcd_%0d", k), abcd, k < 48 ? k / 3 : 0);
        bus.start = (k % 10 == 5) || k == 48;
      end
    end
    chk("done_edge", done_at, 49);
    e = sb.pop_front();
    chk("tt", bus.truth_table, e.tt);
    chk("pass", bus.pass, e.pass);
    chk("cerr", bus.comp_err, e.cerr);
    chk("eidx", bus.err_index, e.eidx);
    chk("busy_off", bus.busy, 0);
    chk("abcd_idle", abcd, 0);
    if (order) begin
      @(posedge clk);
      #1;
      chk("done_held", bus.done, 1);
      chk("no_restart", bus.busy, 0);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", bus.busy, 0);
    sweep(1'b1);
    xor_mode = 1'b1;
    sweep(1'b0);
    xor_mode = 1'b0;
    fault = 1'b1;
    sweep(1'b0);
    fault = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 100 && abcd != 4'd7; n++) @(negedge clk);
    chk("reach_idx7", abcd, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
